// File: rtl/fir_coef_bank_ctrl_pkg.sv
// Shared types and default sizing for the FIR coefficient bank controller.
// The default sizes describe the standard 24-tap, 3-group datapath. Modules
// take their own parameters, and these values are the defaults for them.
package fir_structs;

    localparam int DEF_NUM_TAPS   = 24;
    localparam int DEF_NUM_GROUPS = 3;
    localparam int DEF_COEF_W     = 32;
    localparam int DEF_ADDR_W     = 5;

    localparam int TAPS_PER_GROUP = DEF_NUM_TAPS / DEF_NUM_GROUPS;

    typedef enum logic [1:0] {
        CoefEmpty,
        CoefLoading,
        CoefPending,
        CoefReady
    } coef_state_type;

endpackage

// File: rtl/fir_coef_regfile.sv
// Two-bank coefficient register array.
// It has one write port, which addresses a bank and a tap. It has one read
// port, which returns the whole coefficient group of a bank. Tap
// g*TAPS_PER_GRP+i appears in slice i of the read data. A group index past
// the last group reads as all zeros.
module fir_coef_regfile
    import fir_structs::*;
#(
    parameter int NUM_TAPS     = DEF_NUM_TAPS,
    parameter int NUM_GROUPS   = DEF_NUM_GROUPS,
    parameter int COEF_W       = DEF_COEF_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int TAPS_PER_GRP = TAPS_PER_GROUP
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           wr_en_i,
    input  logic                           wr_bank_i,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [COEF_W-1:0]              wr_data_i,
    input  logic                           rd_bank_i,
    input  logic [1:0]                     rd_group_i,
    output logic [TAPS_PER_GRP*COEF_W-1:0] rd_data_o
);

    logic [COEF_W-1:0] bank_q [2][NUM_TAPS];

    // Both banks are cleared on reset. After reset, one tap is written per enabled cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    bank_q[b][t] <= '0;
                end
            end
        end else if (wr_en_i) begin
            bank_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Gather the selected group of the selected bank. A group index out of range gives zero.
    always_comb begin
        logic [ADDR_W-1:0] tapIdx;
        rd_data_o = '0;
        tapIdx    = '0;
        if (int'(rd_group_i) < NUM_GROUPS) begin
            for (int i = 0; i < TAPS_PER_GRP; i++) begin
                tapIdx = ADDR_W'(int'(rd_group_i) * TAPS_PER_GRP + i);
                rd_data_o[i*COEF_W +: COEF_W] = bank_q[rd_bank_i][tapIdx];
            end
        end
    end

endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered coefficient bank controller for the FIR datapath.
// Writes go into the shadow bank. A write mask tracks which taps of the
// shadow bank have been written. When the mask is full, the set waits in
// PENDING until the multiplier is idle, and then the banks swap. This keeps
// a sample in flight from seeing coefficients from two different sets. The
// very first set swaps in straight away, because nothing can be running
// before a valid set exists.
module fir_coef_bank_ctrl
    import fir_structs::*;
#(
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int NUM_GROUPS = DEF_NUM_GROUPS,
    parameter int COEF_W     = DEF_COEF_W,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       PushCoef,
    input  logic [ADDR_W-1:0]                          CoefAddr,
    input  logic [COEF_W-1:0]                          CoefIn,
    input  logic                                       multiplier_idle,
    input  logic [1:0]                                 group_sel,
    output logic [(NUM_TAPS/NUM_GROUPS)*COEF_W-1:0]    coef_group,
    output logic                                       coef_valid,
    output logic                                       swap_pending,
    output logic                                       load_busy,
    output logic                                       addr_err,
    output logic                                       swap_done
);

    localparam int T = NUM_TAPS / NUM_GROUPS;

    coef_state_type       state_q, state_d;
    logic [NUM_TAPS-1:0]  writeMask_q, writeMask_d;
    logic                 activeSel_q, activeSel_d;
    logic                 coefValid_q, coefValid_d;
    logic                 addrErr_q, addrErr_d;
    logic [T*COEF_W-1:0]  coefGroup_q, coefGroup_d;

    logic                 wrValid;
    logic                 doSwap;
    logic [T*COEF_W-1:0]  rdData;

    assign wrValid   = PushCoef && (int'(CoefAddr) < NUM_TAPS);
    assign addrErr_d = PushCoef && !(int'(CoefAddr) < NUM_TAPS);

    // Coefficient storage. Writes always go to the bank that is not active.
    // A write on the swap cycle still lands in the outgoing shadow bank, which becomes the active bank.
    fir_coef_regfile #(
        .NUM_TAPS     (NUM_TAPS),
        .NUM_GROUPS   (NUM_GROUPS),
        .COEF_W       (COEF_W),
        .ADDR_W       (ADDR_W),
        .TAPS_PER_GRP (T)
    ) u_regfile (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (wrValid),
        .wr_bank_i  (!activeSel_q),
        .wr_addr_i  (CoefAddr),
        .wr_data_i  (CoefIn),
        .rd_bank_i  (activeSel_q),
        .rd_group_i (group_sel),
        .rd_data_o  (rdData)
    );

    // Next-state logic for the load/swap FSM, the shadow write mask and the swap pulse.
    always_comb begin
        state_d     = state_q;
        writeMask_d = writeMask_q;
        activeSel_d = activeSel_q;
        coefValid_d = coefValid_q;
        doSwap      = 1'b0;

        if (wrValid) begin
            writeMask_d = writeMask_q | (NUM_TAPS'(1) << CoefAddr);
        end

        case (state_q)
            CoefEmpty: begin
                if (wrValid) begin
                    state_d = CoefLoading;
                end
            end
            CoefLoading: begin
                if (&writeMask_q) begin
                    state_d = CoefPending;
                end
            end
            CoefPending: begin
                if (multiplier_idle || !coefValid_q) begin
                    doSwap      = 1'b1;
                    activeSel_d = !activeSel_q;
                    writeMask_d = '0;
                    coefValid_d = 1'b1;
                    state_d     = CoefReady;
                end
            end
            CoefReady: begin
                if (wrValid) begin
                    state_d = CoefLoading;
                end
            end
            default: begin
                state_d = CoefEmpty;
            end
        endcase
    end

    // The group read path is registered. It samples the bank that is active on the current cycle.
    assign coefGroup_d = rdData;

    // Register all controller state. Reset discards any partly loaded set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CoefEmpty;
            writeMask_q <= '0;
            activeSel_q <= 1'b0;
            coefValid_q <= 1'b0;
            addrErr_q   <= 1'b0;
            coefGroup_q <= '0;
        end else begin
            state_q     <= state_d;
            writeMask_q <= writeMask_d;
            activeSel_q <= activeSel_d;
            coefValid_q <= coefValid_d;
            addrErr_q   <= addrErr_d;
            coefGroup_q <= coefGroup_d;
        end
    end

    assign coef_group   = coefGroup_q;
    assign coef_valid   = coefValid_q;
    assign swap_pending = (state_q == CoefPending);
    assign load_busy    = (state_q == CoefLoading);
    assign addr_err     = addrErr_q;
    assign swap_done    = doSwap;

endmodule
